// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Requesters are granted round-robin over valid/ready handshakes; the
//   granted operands and select are registered onto alu_op1/alu_op2/
//   alu_select, the ALU result is captured one cycle later and returned
//   with the requester id over a rsp_valid/rsp_ready handshake.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          request handshake, N = 0, 1
//   reqN_op1/op2/sel          request operands and ALU select
//   alu_op1/op2/select        registered operands to the ALU
//   alu_out, alu_carry        ALU result (combinational from alu_*)
//   rsp_valid/ready           response handshake
//   rsp_id/out/carry          captured response payload
// Optional feature (macro ALU_ARB_STATS_EN): grant_cnt0/grant_cnt1,
//   16-bit saturating per-requester grant counters.
module alu_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [SEL_W-1:0] req1_sel,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [SEL_W-1:0] alu_select,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_carry
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             grant1;

  // Next-state, grant decode and handshake-driven captures
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    id_d        = id_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_carry_d = rsp_carry_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    // req1 wins when it is the only requester or when both ask and prio points at it
    grant1      = req1_valid && (!req0_valid || prio_q);

    case (state_q)
      IDLE: begin
        req0_ready = req0_valid && !grant1;
        req1_ready = grant1;
        if (req0_ready || req1_ready) begin
          op1_d   = req1_ready ? req1_op1 : req0_op1;
          op2_d   = req1_ready ? req1_op2 : req0_op2;
          sel_d   = req1_ready ? req1_sel : req0_sel;
          id_d    = req1_ready;
          prio_d  = !req1_ready;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_out_d   = alu_out;
        rsp_carry_d = alu_carry;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      id_q        <= id_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_select = sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_out    = rsp_out_q;
  assign rsp_carry  = rsp_carry_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  // Saturating grant counters, one per requester
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req0_ready && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
    if (req1_ready && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a reference ALU closes the alu_* loop and a
// queue of expected responses is filled at each observed handshake.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [63:0] req0_op1, req0_op2;
  logic [3:0]  req0_sel;
  logic        req1_valid, req1_ready;
  logic [63:0] req1_op1, req1_op2;
  logic [3:0]  req1_sel;
  logic [63:0] alu_op1, alu_op2, alu_out;
  logic [3:0]  alu_select;
  logic        alu_carry;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [63:0] rsp_out;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
  logic [15:0] exp_cnt0 = 16'd0, exp_cnt1 = 16'd0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        id;
    logic [63:0] out;
    logic        carry;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Reference ALU: {carry, result}
  function automatic logic [64:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] s);
    logic [64:0] r;
    case (s)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} - {1'b0, b};
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      4'd5:    r = {1'b0, ~a};
      4'd6:    r = {a, 1'b0};
      4'd7:    r = {a[0], 1'b0, a[63:1]};
      4'd8:    r = {1'b0, a} + 65'd1;
      4'd9:    r = {1'b0, a} - 65'd1;
      4'd10:   r = {1'b0, ~(a & b)};
      4'd11:   r = {1'b0, ~(a | b)};
      4'd12:   r = {1'b0, b};
      4'd13:   r = {1'b0, a};
      4'd14:   r = {1'b0, a} + {1'b0, b} + 65'd1;
      default: r = {1'b0, 63'd0, (a < b)};
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_out} = alu_ref(alu_op1, alu_op2, alu_select);

  alu_arbiter #(.WIDTH(64), .SEL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op1   (req0_op1),
    .req0_op2   (req0_op2),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op1   (req1_op1),
    .req1_op2   (req1_op2),
    .req1_sel   (req1_sel),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_select (alu_select),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_out    (rsp_out),
    .rsp_carry  (rsp_carry)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

`ifdef ALU_ARB_STATS_EN
  always @(posedge clk) begin
    if (rst) begin
      exp_cnt0 <= 16'd0;
      exp_cnt1 <= 16'd0;
    end else begin
      if (req0_valid && req0_ready && exp_cnt0 != 16'hFFFF) exp_cnt0 <= exp_cnt0 + 16'd1;
      if (req1_valid && req1_ready && exp_cnt1 != 16'hFFFF) exp_cnt1 <= exp_cnt1 + 16'd1;
    end
  end
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk_exp(input logic id, input logic [63:0] a, input logic [63:0] b,
                                  input logic [3:0] s);
    logic [64:0] r;
    exp_t e;
    r       = alu_ref(a, b, s);
    e.id    = id;
    e.out   = r[63:0];
    e.carry = r[64];
    return e;
  endfunction

  // Drive one request and wait (bounded) for its handshake edge
  task automatic issue(input logic id, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] s, output bit ok);
    ok = 1'b0;
    if (id) begin
      req1_op1 = a; req1_op2 = b; req1_sel = s; req1_valid = 1'b1;
    end else begin
      req0_op1 = a; req0_op2 = b; req0_sel = s; req0_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin
        sb.push_back(mk_exp(id, a, b, s));
        ok = 1'b1;
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_op1 = '0; req0_op2 = '0; req0_sel = '0;
    req1_op1 = '0; req1_op2 = '0; req1_sel = '0;
    do_reset();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_out, rsp_carry, alu_op1, alu_op2, alu_select,
         req0_ready, req1_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rsp_valid=%b rsp_id=%b rsp_out=%h alu_op1=%h alu_select=%h rdy=%b%b, required all zero",
               rsp_valid, rsp_id, rsp_out, alu_op1, alu_select, req0_ready, req1_ready);
    end
  endtask

  task automatic test_reset_mid_exec();
    exp_t e, got;
    bit seen;
    bit ok;
    req0_op1 = 64'h071A; req0_op2 = 64'h1230; req0_sel = 4'h0; req0_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL rme_first_grant: req0_ready=%b, required 1", req0_ready);
    end
    tick();                      // handshake edge, now in EXEC
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();                      // reset lands during EXEC
    rst = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_out, rsp_carry, alu_op1, alu_op2, alu_select,
         req0_ready, req1_ready} !== '0) begin
      errors++;
      $display("FAIL rme_outputs: rsp_valid=%b rsp_out=%h alu_op1=%h alu_op2=%h, required all zero",
               rsp_valid, rsp_out, alu_op1, alu_op2);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL rme_no_response: rsp_valid seen=1, required 0");
    end
    // Both valid after reset: prio restarts at requester 0
    req1_op1 = 64'h55; req1_op2 = 64'h3; req1_sel = 4'h1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rme_next_grant: ready=%b%b, required 10", req0_ready, req1_ready);
    end
    sb.push_back(mk_exp(1'b0, req0_op1, req0_op2, req0_sel));
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (rsp_valid) begin
        got = {rsp_id, rsp_out, rsp_carry};
        ok  = 1'b1;
      end
      tick();
    end
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL rme_rsp: ok=%b id=%b out=%h carry=%b, required id=%b out=%h carry=%b",
               ok, got.id, got.out, got.carry, e.id, e.out, e.carry);
    end
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    req0_op1 = 64'h071A; req0_op2 = 64'h1230; req0_sel = 4'h0; req0_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready: ready=%b%b, required 10", req0_ready, req1_ready);
    end
    e = mk_exp(1'b0, req0_op1, req0_op2, req0_sel);
    tick();                      // handshake edge N, valid kept high
    checks++;
    if (req0_ready !== 1'b0 || rsp_valid !== 1'b0 || alu_op1 !== 64'h071A ||
        alu_op2 !== 64'h1230 || alu_select !== 4'h0) begin
      errors++;
      $display("FAIL single_exec: req0_ready=%b rsp_valid=%b alu_op1=%h alu_op2=%h sel=%h, required 0 0 071a 1230 0",
               req0_ready, rsp_valid, alu_op1, alu_op2, alu_select);
    end
    tick();                      // edge N+1
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 64'h194A || rsp_carry !== 1'b0 ||
        req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: valid=%b id=%b out=%h carry=%b rdy=%b, required 1 0 194a 0 0",
               rsp_valid, rsp_id, rsp_out, rsp_carry, req0_ready);
    end
    checks++;
    if (rsp_out !== e.out || rsp_carry !== e.carry) begin
      errors++; $display("FAIL single_model: out=%h, required %h", rsp_out, e.out);
    end
    req0_valid = 1'b0;
    tick();                      // back to IDLE
  endtask

  task automatic test_contention();
    exp_t e;
    int grants, rsps, last_cyc;
    do_reset();
    rsp_ready = 1'b1;
    req0_op1 = 64'hFFFF_FFFF_FFFF_FFF0; req0_op2 = 64'h20; req0_sel = 4'h0;
    req1_op1 = 64'h10;                  req1_op2 = 64'h30; req1_sel = 4'h1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    grants = 0; rsps = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 60 && rsps < 4; cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        checks++;
        if (req1_ready !== logic'(grants % 2) || (req0_ready && req1_ready)) begin
          errors++;
          $display("FAIL cont_grant%0d: ready=%b%b, required id %0d", grants, req0_ready,
                   req1_ready, grants % 2);
        end
        if (grants > 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++; $display("FAIL cont_spacing: %0d cycles, required 3", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        if (req1_ready) sb.push_back(mk_exp(1'b1, req1_op1, req1_op2, req1_sel));
        else            sb.push_back(mk_exp(1'b0, req0_op1, req0_op2, req0_sel));
        grants++;
      end
      if (rsp_valid) begin
        e = sb.pop_front();
        checks++;
        if (rsp_id !== e.id || rsp_out !== e.out || rsp_carry !== e.carry) begin
          errors++;
          $display("FAIL cont_rsp%0d: id=%b out=%h carry=%b, required id=%b out=%h carry=%b",
                   rsps, rsp_id, rsp_out, rsp_carry, e.id, e.out, e.carry);
        end
        rsps++;
      end
      tick();
      if (grants == 4) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (rsps != 4 || grants != 4) begin
      errors++; $display("FAIL cont_timeout: grants=%0d rsps=%0d, required 4 4", grants, rsps);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit ok;
    bit bad;
    logic [63:0] hold_out;
    logic hold_id;
    rsp_ready = 1'b0;
    issue(1'b1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 4'h0, ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (rsp_valid) ok = 1'b1;
      else tick();
    end
    e = sb.pop_front();
    checks++;
    if (!ok || rsp_id !== e.id || rsp_out !== e.out || rsp_carry !== e.carry) begin
      errors++;
      $display("FAIL bp_rsp: ok=%b id=%b out=%h carry=%b, required id=%b out=%h carry=%b",
               ok, rsp_id, rsp_out, rsp_carry, e.id, e.out, e.carry);
    end
    hold_out = rsp_out; hold_id = rsp_id;
    req0_valid = 1'b1; req1_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_out !== hold_out || rsp_id !== hold_id ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_stable: valid=%b out=%h id=%b rdy=%b%b, required 1 %h %b 00",
               rsp_valid, rsp_out, rsp_id, req0_ready, req1_ready, hold_out, hold_id);
    end
    rsp_ready = 1'b1;
    tick();                      // RESP -> IDLE
    checks++;
    if (rsp_valid !== 1'b0 || (req0_ready | req1_ready) !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: rsp_valid=%b rdy=%b%b, required 0 and one ready",
               rsp_valid, req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_select_sweep();
    exp_t e;
    bit ok;
    rsp_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      issue(1'b1, 64'h071A, 64'h1230, 4'(s), ok);
      checks++;
      if (!ok || alu_select !== 4'(s) || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL sweep_exec%0d: ok=%b alu_select=%h rsp_valid=%b, required %h 0",
                 s, ok, alu_select, rsp_valid, 4'(s));
      end
      tick();
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_out !== e.out || rsp_carry !== e.carry) begin
        errors++;
        $display("FAIL sweep_rsp%0d: valid=%b id=%b out=%h carry=%b, required 1 1 %h %b",
                 s, rsp_valid, rsp_id, rsp_out, rsp_carry, e.out, e.carry);
      end
      tick();
    end
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    #1;
    checks++;
    if (grant_cnt0 !== exp_cnt0 || grant_cnt1 !== exp_cnt1) begin
      errors++;
      $display("FAIL stats_cnt: cnt0=%0d cnt1=%0d, required %0d %0d",
               grant_cnt0, grant_cnt1, exp_cnt0, exp_cnt1);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    test_reset();
    test_reset_mid_exec();
    test_single();
    test_contention();
    test_backpressure();
    test_select_sweep();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 64-bit ALU (operands Op1/Op2, 4-bit select, result plus carry_out) between two requesters. Each requester submits an operation over a valid/ready handshake. The block grants requesters round-robin, drives registered operands into the ALU, captures the result, and returns it with the requester ID over a response handshake. It sits between the ALU instance and the requesting units at the lab top level.

## Interface
Parameters:
- WIDTH, 64, operand/result width
- SEL_W, 4, ALU select width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op1 / req0_op2  in  WIDTH  requester 0 operands
- req0_sel  in  SEL_W  requester 0 ALU select
- req1_valid, req1_ready, req1_op1, req1_op2, req1_sel: same as requester 0, for requester 1
- alu_op1 / alu_op2  out  WIDTH  registered operands to ALU Op1/Op2
- alu_select  out  SEL_W  registered select to ALU
- alu_out  in  WIDTH  ALU result (combinational from alu_* outputs)
- alu_carry  in  1  ALU carry_out
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the operation
- rsp_out  out  WIDTH  captured result
- rsp_carry  out  1  captured carry

## Operation
States: IDLE, EXEC, RESP.

IDLE
- req*_ready is asserted only in IDLE, and only for the granted requester. At most one ready is high per cycle.
- Grant selection:
  - Only one requester valid: grant it.
  - Both valid: grant the requester indicated by prio. prio is 0 after reset.
- On handshake (valid & ready):
  - latch op1/op2/sel into alu_op1/alu_op2/alu_select;
  - latch the ID;
  - set prio to the other requester;
  - go to EXEC.

EXEC
- One cycle. Capture alu_out/alu_carry into rsp_out/rsp_carry, with rsp_id = latched ID.
- Go to RESP.

RESP
- rsp_valid = 1.
- rsp_id, rsp_out and rsp_carry stay stable until rsp_ready.
- On rsp_ready: go to IDLE.

General rules
- No new request is accepted in EXEC or RESP. req*_ready = 0 in those states.
- alu_op1, alu_op2 and alu_select hold their last value outside EXEC. They change only on a handshake.
- Requester fields are sampled only on the handshake cycle. Changing them while valid is low or ready is low has no effect.
- A requester that deasserts valid before its handshake loses nothing: no state changes.

Reset
- All outputs return to the following values: req*_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_out = 0, rsp_carry = 0, alu_op1 = 0, alu_op2 = 0, alu_select = 0.
- prio = 0 and state = IDLE.
- Reset in EXEC or RESP discards the in-flight operation. No response is emitted.

## Timing
- Handshake at edge N → alu_* valid after N → result captured at edge N+1 → rsp_valid high after N+1.
- Minimum request-to-response latency is 2 cycles.
- Back-to-back throughput with rsp_ready tied high: one operation per 3 cycles (IDLE, EXEC, RESP).
- rsp_ready is sampled only in RESP. rsp_ready high in other states is ignored.
- req*_ready is a registered-state decode. It is combinational only on the req*_valid signals and prio; it never depends on rsp_ready.

## Configuration
- Macro ALU_ARB_STATS_EN.
- Defined:
  - adds output ports grant_cnt0 and grant_cnt1, each 16 bits;
  - each counter increments on the respective requester's handshake;
  - each counter saturates at 16'hFFFF;
  - both counters clear on rst.
- Undefined: the ports and the counters do not exist. All other behaviour is identical.

## Test plan
- Reset mid-EXEC:
  - Stimulus: req0 with op1 = 64'h071A, op2 = 64'h1230, sel = 0; rst asserted during EXEC.
  - Required response: no rsp_valid; all outputs return to their reset values; next grant goes to req0 (prio = 0).
- Single request:
  - Stimulus: req0 with op1 = 64'h071A, op2 = 64'h1230, sel = 4'h0 (add); rsp_ready held high.
  - Required response: req0_ready high 1 cycle; rsp_valid 2 cycles after handshake; rsp_id = 0; rsp_out = 64'h194A; rsp_carry = 0.
- Contention:
  - Stimulus: both requesters valid continuously for 4 operations.
  - Required response: grants alternate 0, 1, 0, 1; rsp_id sequence matches; each response's rsp_out equals the model ALU result for that requester's operands.
- Response backpressure:
  - Stimulus: rsp_ready held low for 5 cycles in RESP.
  - Required response: rsp_valid, rsp_out and rsp_id stable; req0_ready and req1_ready stay 0; on rsp_ready, IDLE is reached the next cycle.
- Select sweep:
  - Stimulus: req1 issues sel = 0..15 with op1 = 64'h071A, op2 = 64'h1230.
  - Required response: each rsp_out/rsp_carry matches the ALU reference model; alu_select equals the requested sel during EXEC.
- Counter saturation (ALU_ARB_STATS_EN defined):
  - Stimulus: 65,537 grants to req0.
  - Required response: grant_cnt0 = 16'hFFFF; grant_cnt1 = 0.
